// File: rtl/clksw_initiator.sv
// Initiator side of the hsclk_by4 / lsclk CPU clock handover.
// Drives hienable into the selection retimers and sequences each switch from their synchronised feedback.
module clksw_initiator #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LS_DWELL    = 16,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic       hsclk_r,
    input  logic       rst_b,
    input  logic       slow_req,
    input  logic       cpuclk,
    input  logic       hiselect,
    input  logic       loselect,
    output logic       hienable,
    output logic       in_hs,
    output logic       in_ls,
    output logic       busy,
    output logic       timeout_err,
    output logic       overlap_err,
    output logic [7:0] switch_count
);

    // state   | meaning
    // HS_RUN  | running on hsclk_by4, watching slow_req
    // HS_DROP | hienable lowered, waiting for hiselect to fall
    // LS_WAIT | waiting for loselect to rise (reset state)
    // LS_RUN  | running on lsclk, dwell timer active
    // LS_DROP | hienable raised, waiting for loselect to fall
    // HS_WAIT | waiting for hiselect to rise
    typedef enum logic [2:0] {
        HS_RUN  = 3'd0,
        HS_DROP = 3'd1,
        LS_WAIT = 3'd2,
        LS_RUN  = 3'd3,
        LS_DROP = 3'd4,
        HS_WAIT = 3'd5
    } state_t;

    localparam logic [7:0] DWELL_LD = 8'(LS_DWELL);
    localparam logic [7:0] TO_LIM   = 8'(TIMEOUT);

    logic [SYNC_STAGES-1:0] hi_sync_q, hi_sync_d;
    logic [SYNC_STAGES-1:0] lo_sync_q, lo_sync_d;
    logic [SYNC_STAGES-1:0] ck_sync_q, ck_sync_d;
    logic                   ck_s_d_q, ck_s_d_d;

    state_t     state_q, state_d;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] to_cnt_q, to_cnt_d;
    logic [7:0] switch_count_q, switch_count_d;
    logic       hienable_q, hienable_d;
    logic       in_hs_q, in_hs_d;
    logic       in_ls_q, in_ls_d;
    logic       busy_q, busy_d;
    logic       timeout_err_q, timeout_err_d;
    logic       overlap_err_q, overlap_err_d;

    logic hi_s, lo_s, ck_s, phi2_ok, in_wait;

    assign hi_s = hi_sync_q[SYNC_STAGES-1];
    assign lo_s = lo_sync_q[SYNC_STAGES-1];
    assign ck_s = ck_sync_q[SYNC_STAGES-1];
    // cpuclk seen high on two consecutive samples: safely inside PHI2
    assign phi2_ok = ck_s & ck_s_d_q;
    assign in_wait = (state_q == HS_DROP) || (state_q == LS_WAIT) ||
                     (state_q == LS_DROP) || (state_q == HS_WAIT);

    always_comb begin
        hi_sync_d = {hi_sync_q[SYNC_STAGES-2:0], hiselect};
        lo_sync_d = {lo_sync_q[SYNC_STAGES-2:0], loselect};
        ck_sync_d = {ck_sync_q[SYNC_STAGES-2:0], cpuclk};
        ck_s_d_d  = ck_s;

        state_d        = state_q;
        dwell_d        = dwell_q;
        hienable_d     = hienable_q;
        switch_count_d = switch_count_q;
        timeout_err_d  = timeout_err_q;
        overlap_err_d  = overlap_err_q | (hi_s & lo_s);

        case (state_q)
            HS_RUN: begin
                if (slow_req && phi2_ok) begin
                    hienable_d = 1'b0;
                    state_d    = HS_DROP;
                end
            end
            HS_DROP: begin
                if (!hi_s) state_d = LS_WAIT;
            end
            LS_WAIT: begin
                if (lo_s) begin
                    state_d = LS_RUN;
                    dwell_d = DWELL_LD;
                end
            end
            LS_RUN: begin
                if (dwell_q != 8'd0) begin
                    dwell_d = dwell_q - 8'd1;
                end else if (!slow_req && phi2_ok) begin
                    hienable_d = 1'b1;
                    state_d    = LS_DROP;
                end
            end
            LS_DROP: begin
                if (!lo_s) state_d = HS_WAIT;
            end
            HS_WAIT: begin
                if (hi_s) begin
                    state_d        = HS_RUN;
                    switch_count_d = switch_count_q + 8'd1;
                end
            end
            default: state_d = LS_WAIT;
        endcase

        // Timeout counter restarts on every state change and saturates at the limit
        to_cnt_d = 8'd0;
        if (in_wait && (state_d == state_q)) begin
            to_cnt_d = (to_cnt_q == TO_LIM) ? to_cnt_q : to_cnt_q + 8'd1;
            if (to_cnt_d == TO_LIM) timeout_err_d = 1'b1;
        end

        in_hs_d = (state_d == HS_RUN);
        in_ls_d = (state_d == LS_RUN);
        busy_d  = (state_d == HS_DROP) || (state_d == LS_WAIT) ||
                  (state_d == LS_DROP) || (state_d == HS_WAIT);
    end

    always_ff @(posedge hsclk_r or negedge rst_b) begin
        if (!rst_b) begin
            hi_sync_q      <= '0;
            lo_sync_q      <= '0;
            ck_sync_q      <= '0;
            ck_s_d_q       <= 1'b0;
            state_q        <= LS_WAIT;
            dwell_q        <= 8'd0;
            to_cnt_q       <= 8'd0;
            switch_count_q <= 8'd0;
            hienable_q     <= 1'b0;
            in_hs_q        <= 1'b0;
            in_ls_q        <= 1'b0;
            busy_q         <= 1'b1;
            timeout_err_q  <= 1'b0;
            overlap_err_q  <= 1'b0;
        end else begin
            hi_sync_q      <= hi_sync_d;
            lo_sync_q      <= lo_sync_d;
            ck_sync_q      <= ck_sync_d;
            ck_s_d_q       <= ck_s_d_d;
            state_q        <= state_d;
            dwell_q        <= dwell_d;
            to_cnt_q       <= to_cnt_d;
            switch_count_q <= switch_count_d;
            hienable_q     <= hienable_d;
            in_hs_q        <= in_hs_d;
            in_ls_q        <= in_ls_d;
            busy_q         <= busy_d;
            timeout_err_q  <= timeout_err_d;
            overlap_err_q  <= overlap_err_d;
        end
    end

    assign hienable     = hienable_q;
    assign in_hs        = in_hs_q;
    assign in_ls        = in_ls_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;
    assign overlap_err  = overlap_err_q;
    assign switch_count = switch_count_q;

endmodule

// File: tb/tb_clksw_initiator.sv
// Directed bench for clksw_initiator; the bench plays the retimers by driving hiselect/loselect by hand.
module tb_clksw_initiator;

    logic       hsclk_r = 1'b0;
    logic       rst_b, slow_req, cpuclk, hiselect, loselect;
    logic       hienable, in_hs, in_ls, busy, timeout_err, overlap_err;
    logic [7:0] switch_count;
    logic [7:0] exp_cnt;
    int         checks = 0;
    int         errors = 0;

    always #30 hsclk_r = ~hsclk_r;

    clksw_initiator #(
        .SYNC_STAGES(2),
        .LS_DWELL   (16),
        .TIMEOUT    (20)
    ) dut (
        .hsclk_r     (hsclk_r),
        .rst_b       (rst_b),
        .slow_req    (slow_req),
        .cpuclk      (cpuclk),
        .hiselect    (hiselect),
        .loselect    (loselect),
        .hienable    (hienable),
        .in_hs       (in_hs),
        .in_ls       (in_ls),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overlap_err (overlap_err),
        .switch_count(switch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge hsclk_r);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hienable"},  32'(hienable),     0);
        check({tag, "_in_hs"},     32'(in_hs),        0);
        check({tag, "_in_ls"},     32'(in_ls),        0);
        check({tag, "_busy"},      32'(busy),         1);
        check({tag, "_timeout"},   32'(timeout_err),  0);
        check({tag, "_overlap"},   32'(overlap_err),  0);
        check({tag, "_count"},     32'(switch_count), 0);
    endtask

    // LS_RUN -> HS_RUN, retimers answer promptly
    task automatic go_hs();
        slow_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (hienable) break;
        end
        check("go_hs_hienable", 32'(hienable), 1);
        loselect = 1'b0;
        tick(1);
        hiselect = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (in_hs) break;
        end
        check("go_hs_in_hs", 32'(in_hs), 1);
        exp_cnt++;
    endtask

    // HS_RUN -> LS_RUN
    task automatic go_ls();
        slow_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!hienable) break;
        end
        check("go_ls_hienable", 32'(hienable), 0);
        hiselect = 1'b0;
        tick(1);
        loselect = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (in_ls) break;
        end
        check("go_ls_in_ls", 32'(in_ls), 1);
    endtask

    initial begin
        rst_b = 1'b0; slow_req = 1'b1; cpuclk = 1'b0;
        hiselect = 1'b0; loselect = 1'b0; exp_cnt = 8'd0;
        tick(2);
        check_reset_values("reset");

        // Reset release straight into low speed
        rst_b = 1'b1;
        loselect = 1'b1;
        tick(2);
        check("t1_in_ls_early", 32'(in_ls), 0);
        check("t1_busy_early",  32'(busy),   1);
        tick(1);
        check("t1_in_ls",    32'(in_ls),    1);
        check("t1_busy",     32'(busy),     0);
        check("t1_hienable", 32'(hienable), 0);

        // Return to high speed after the 16-cycle dwell
        slow_req = 1'b0;
        cpuclk   = 1'b1;
        tick(16);
        check("t2_dwell_hienable", 32'(hienable), 0);
        check("t2_dwell_in_ls",    32'(in_ls),    1);
        tick(1);
        check("t2_hienable_rise", 32'(hienable), 1);
        check("t2_in_ls_drop",    32'(in_ls),    0);
        check("t2_busy",          32'(busy),     1);
        loselect = 1'b0;
        tick(1);
        hiselect = 1'b1;
        tick(2);
        check("t2_hs_wait_busy",  32'(busy),  1);
        check("t2_hs_wait_in_hs", 32'(in_hs), 0);
        tick(1);
        check("t2_in_hs", 32'(in_hs),        1);
        check("t2_busy0", 32'(busy),         0);
        check("t2_count", 32'(switch_count), 1);
        exp_cnt = 8'd1;

        // phi2_ok gating of the HS -> LS request
        cpuclk = 1'b0;
        tick(3);
        slow_req = 1'b1;
        tick(1);
        slow_req = 1'b0;
        tick(3);
        check("t3_pulse_hienable", 32'(hienable), 1);
        check("t3_pulse_in_hs",    32'(in_hs),    1);
        slow_req = 1'b1;
        tick(5);
        check("t3_hold_hienable", 32'(hienable), 1);
        cpuclk = 1'b1;
        tick(3);
        check("t3_phi2_wait_hienable", 32'(hienable), 1);
        tick(1);
        check("t3_hienable_fall", 32'(hienable), 0);
        check("t3_busy",          32'(busy),     1);
        hiselect = 1'b0;
        tick(1);
        loselect = 1'b1;
        tick(2);
        check("t3_ls_wait_busy",  32'(busy),  1);
        check("t3_ls_wait_in_ls", 32'(in_ls), 0);
        tick(1);
        check("t3_in_ls",    32'(in_ls),       1);
        check("t3_no_to",    32'(timeout_err), 0);
        check("t3_no_ovl",   32'(overlap_err), 0);

        // Timeout in LS_WAIT with loselect stuck low
        go_hs();
        check("t4_count", 32'(switch_count), 32'(exp_cnt));
        slow_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!hienable) break;
        end
        check("t4_hienable_fall", 32'(hienable), 0);
        hiselect = 1'b0;
        tick(22);
        check("t4_timeout_before", 32'(timeout_err), 0);
        check("t4_busy_before",    32'(busy),        1);
        tick(1);
        check("t4_timeout", 32'(timeout_err), 1);
        check("t4_busy",    32'(busy),        1);
        tick(5);
        check("t4_still_waiting", 32'(busy),        1);
        check("t4_not_ls",        32'(in_ls),       0);
        check("t4_sticky",        32'(timeout_err), 1);
        loselect = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (in_ls) break;
        end
        check("t4_recover_in_ls", 32'(in_ls), 1);

        // Overlap of both selects, three cycles
        check("t5_ovl_clear", 32'(overlap_err), 0);
        hiselect = 1'b1;
        tick(2);
        check("t5_ovl_early", 32'(overlap_err), 0);
        tick(1);
        check("t5_ovl_set", 32'(overlap_err), 1);
        hiselect = 1'b0;
        loselect = 1'b0;
        tick(5);
        check("t5_ovl_sticky", 32'(overlap_err), 1);
        loselect = 1'b1;
        tick(3);
        check("t5_in_ls", 32'(in_ls), 1);

        // 257 round trips: counter wraps
        for (int n = 0; n < 257; n++) begin
            go_hs();
            if (n == 253) check("t6_count_wrap0", 32'(switch_count), 0);
            go_ls();
        end
        check("t6_count_model", 32'(switch_count), 32'(exp_cnt));
        check("t6_count_final", 32'(switch_count), 3);

        // Reset in HS_WAIT
        slow_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (hienable) break;
        end
        check("t6_hienable", 32'(hienable), 1);
        loselect = 1'b0;
        tick(5);
        check("t6_hs_wait_busy", 32'(busy),  1);
        check("t6_hs_wait_hs",   32'(in_hs), 0);
        #5;
        rst_b = 1'b0;
        #1;
        check_reset_values("midreset");
        tick(2);
        rst_b = 1'b1;
        tick(3);
        check("t6_restart_busy",  32'(busy),  1);
        check("t6_restart_in_ls", 32'(in_ls), 0);
        loselect = 1'b1;
        tick(3);
        check("t6_restart_ls", 32'(in_ls), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(60 * 60000);
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1);
    end

endmodule
